// File: rtl/logic_checker.sv
// Response monitor for the 8-bit bitwise logic unit: recomputes all seven lanes per sample and tallies mismatches.
// Optional first-error capture outputs are enabled with `define LOGIC_CHECKER_FIRST_ERR_EN.
//
// state  | meaning
// S_IDLE | waiting for the first start pulse after reset
// S_RUN  | accepting samples until SAMPLE_NUM have been retired
// S_DONE | results frozen; a start pulse begins a new run
module logic_checker #(
  parameter int SAMPLE_NUM = 1000,
  parameter int CNT_W      = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             pi_start,
  input  logic             pi_valid,
  input  logic [7:0]       pi_a,
  input  logic [7:0]       pi_b,
  input  logic [7:0]       pi_c,
  input  logic [7:0]       pi_d,
  input  logic [7:0]       pi_e,
  input  logic [7:0]       pi_f,
  input  logic [7:0]       pi_g,
  input  logic [7:0]       pi_h,
  input  logic [7:0]       pi_i,
  output logic             po_busy,
  output logic             po_done,
  output logic             po_pass,
  output logic [CNT_W-1:0] po_sample_cnt,
  output logic [CNT_W-1:0] po_err_cnt,
  output logic [6:0]       po_err_mask
`ifdef LOGIC_CHECKER_FIRST_ERR_EN
  ,
  output logic             po_first_err_vld,
  output logic [7:0]       po_first_err_a,
  output logic [7:0]       po_first_err_b,
  output logic [6:0]       po_first_err_mask
`endif
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] NUM_C  = CNT_W'(SAMPLE_NUM);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(SAMPLE_NUM - 1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [6:0]       err_mask_q, err_mask_d;
  logic             s1_vld_q, s1_vld_d;
  logic [6:0]       s1_vec_q, s1_vec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
`ifdef LOGIC_CHECKER_FIRST_ERR_EN
  logic [7:0]       s1_a_q, s1_a_d;
  logic [7:0]       s1_b_q, s1_b_d;
  logic             fe_vld_q, fe_vld_d;
  logic [7:0]       fe_a_q, fe_a_d;
  logic [7:0]       fe_b_q, fe_b_d;
  logic [6:0]       fe_mask_q, fe_mask_d;
`endif

  logic [6:0] mism;
  logic       accept;
  logic       start_go;

  assign mism = {pi_i != ~pi_a,
                 pi_h != ~(pi_a ^ pi_b),
                 pi_g != ~(pi_a | pi_b),
                 pi_f != ~(pi_a & pi_b),
                 pi_e != (pi_a ^ pi_b),
                 pi_d != (pi_a | pi_b),
                 pi_c != (pi_a & pi_b)};

  // A start outside RUN wins over any valid presented on the same cycle.
  assign start_go = pi_start && (state_q != S_RUN);
  assign accept   = (state_q == S_RUN) && pi_valid && (acc_cnt_q < NUM_C);

  always_comb begin
    state_d      = state_q;
    acc_cnt_d    = acc_cnt_q;
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    err_mask_d   = err_mask_q;
    s1_vld_d     = accept;
    s1_vec_d     = accept ? mism : s1_vec_q;
`ifdef LOGIC_CHECKER_FIRST_ERR_EN
    s1_a_d       = accept ? pi_a : s1_a_q;
    s1_b_d       = accept ? pi_b : s1_b_q;
    fe_vld_d     = fe_vld_q;
    fe_a_d       = fe_a_q;
    fe_b_d       = fe_b_q;
    fe_mask_d    = fe_mask_q;
`endif

    if (accept) acc_cnt_d = acc_cnt_q + ONE_C;

    if (s1_vld_q) begin
      sample_cnt_d = sample_cnt_q + ONE_C;
      err_mask_d   = err_mask_q | s1_vec_q;
      if ((s1_vec_q != 7'd0) && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + ONE_C;
`ifdef LOGIC_CHECKER_FIRST_ERR_EN
      if ((s1_vec_q != 7'd0) && !fe_vld_q) begin
        fe_vld_d  = 1'b1;
        fe_a_d    = s1_a_q;
        fe_b_d    = s1_b_q;
        fe_mask_d = s1_vec_q;
      end
`endif
    end

    case (state_q)
      S_IDLE:  if (pi_start) state_d = S_RUN;
      S_RUN:   if (s1_vld_q && (sample_cnt_q == LAST_C)) state_d = S_DONE;
      S_DONE:  if (pi_start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    if (start_go) begin
      acc_cnt_d    = '0;
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      err_mask_d   = '0;
      s1_vld_d     = 1'b0;
`ifdef LOGIC_CHECKER_FIRST_ERR_EN
      fe_vld_d     = 1'b0;
      fe_a_d       = '0;
      fe_b_d       = '0;
      fe_mask_d    = '0;
`endif
    end

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_cnt_d == '0);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      acc_cnt_q    <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      err_mask_q   <= '0;
      s1_vld_q     <= 1'b0;
      s1_vec_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
`ifdef LOGIC_CHECKER_FIRST_ERR_EN
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      fe_vld_q     <= 1'b0;
      fe_a_q       <= '0;
      fe_b_q       <= '0;
      fe_mask_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      acc_cnt_q    <= acc_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_mask_q   <= err_mask_d;
      s1_vld_q     <= s1_vld_d;
      s1_vec_q     <= s1_vec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
`ifdef LOGIC_CHECKER_FIRST_ERR_EN
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      fe_vld_q     <= fe_vld_d;
      fe_a_q       <= fe_a_d;
      fe_b_q       <= fe_b_d;
      fe_mask_q    <= fe_mask_d;
`endif
    end
  end

  assign po_busy       = busy_q;
  assign po_done       = done_q;
  assign po_pass       = pass_q;
  assign po_sample_cnt = sample_cnt_q;
  assign po_err_cnt    = err_cnt_q;
  assign po_err_mask   = err_mask_q;
`ifdef LOGIC_CHECKER_FIRST_ERR_EN
  assign po_first_err_vld  = fe_vld_q;
  assign po_first_err_a    = fe_a_q;
  assign po_first_err_b    = fe_b_q;
  assign po_first_err_mask = fe_mask_q;
`endif

endmodule

// File: tb/tb_logic_checker.sv
// Scoreboard bench for logic_checker: three instances (4/16, 12/4, 15/4) share the stimulus bus.
// Expected run results are queued by the driver and checked by monitors on each rising po_done.
module tb_logic_checker;

  typedef struct packed {
    logic [7:0] a, b, c, d, e, f, g, h, i;
  } smp_t;

  typedef struct {
    int         cyc;
    int         sc;
    int         ec;
    logic [6:0] mask;
    logic       pass;
    logic       fv;
    logic [7:0] fa;
    logic [7:0] fb;
    logic [6:0] fm;
  } exp_t;

  localparam smp_t GA = '{8'hA5, 8'h3C, 8'h24, 8'hBD, 8'h99, 8'hDB, 8'h42, 8'h66, 8'h5A};
  localparam smp_t GB = '{8'h0F, 8'hF0, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hF0};
  localparam smp_t BE = '{8'hA5, 8'h3C, 8'h24, 8'hBD, 8'h98, 8'hDB, 8'h42, 8'h66, 8'h5A};
  localparam smp_t BI = '{8'hA5, 8'h3C, 8'h24, 8'hBD, 8'h99, 8'hDB, 8'h42, 8'h66, 8'h00};
  localparam smp_t ZZ = '0;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [2:0] start   = '0;
  logic       pi_valid = 1'b0;
  smp_t       s = '0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  exp_t       q0[$], q1[$], q2[$];

  logic        busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
  logic [15:0] sc0, ec0;
  logic [3:0]  sc1, ec1, sc2, ec2;
  logic [6:0]  m0, m1, m2;
  logic        fv0, fv1, fv2;
  logic [7:0]  fa0, fb0, fa1, fb1, fa2, fb2;
  logic [6:0]  fm0, fm1, fm2;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

`ifdef LOGIC_CHECKER_FIRST_ERR_EN
  `define FE_PORTS0 , .po_first_err_vld(fv0), .po_first_err_a(fa0), .po_first_err_b(fb0), .po_first_err_mask(fm0)
  `define FE_PORTS1 , .po_first_err_vld(fv1), .po_first_err_a(fa1), .po_first_err_b(fb1), .po_first_err_mask(fm1)
  `define FE_PORTS2 , .po_first_err_vld(fv2), .po_first_err_a(fa2), .po_first_err_b(fb2), .po_first_err_mask(fm2)
`else
  `define FE_PORTS0
  `define FE_PORTS1
  `define FE_PORTS2
  assign {fv0, fa0, fb0, fm0} = '0;
  assign {fv1, fa1, fb1, fm1} = '0;
  assign {fv2, fa2, fb2, fm2} = '0;
`endif

  logic_checker #(.SAMPLE_NUM(4), .CNT_W(16)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_start(start[0]), .pi_valid(pi_valid),
    .pi_a(s.a), .pi_b(s.b), .pi_c(s.c), .pi_d(s.d), .pi_e(s.e), .pi_f(s.f), .pi_g(s.g),
    .pi_h(s.h), .pi_i(s.i), .po_busy(busy0), .po_done(done0), .po_pass(pass0),
    .po_sample_cnt(sc0), .po_err_cnt(ec0), .po_err_mask(m0) `FE_PORTS0);

  logic_checker #(.SAMPLE_NUM(12), .CNT_W(4)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_start(start[1]), .pi_valid(pi_valid),
    .pi_a(s.a), .pi_b(s.b), .pi_c(s.c), .pi_d(s.d), .pi_e(s.e), .pi_f(s.f), .pi_g(s.g),
    .pi_h(s.h), .pi_i(s.i), .po_busy(busy1), .po_done(done1), .po_pass(pass1),
    .po_sample_cnt(sc1), .po_err_cnt(ec1), .po_err_mask(m1) `FE_PORTS1);

  logic_checker #(.SAMPLE_NUM(15), .CNT_W(4)) u_dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_start(start[2]), .pi_valid(pi_valid),
    .pi_a(s.a), .pi_b(s.b), .pi_c(s.c), .pi_d(s.d), .pi_e(s.e), .pi_f(s.f), .pi_g(s.g),
    .pi_h(s.h), .pi_i(s.i), .po_busy(busy2), .po_done(done2), .po_pass(pass2),
    .po_sample_cnt(sc2), .po_err_cnt(ec2), .po_err_mask(m2) `FE_PORTS2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic mon(input int k, input logic [31:0] sc, input logic [31:0] ec, input logic [6:0] m,
                     input logic p, input logic fv, input logic [7:0] fa, input logic [7:0] fb,
                     input logic [6:0] fm);
    exp_t e;
    int   sz;
    sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_done dut%0d actual=1 required=0", k);
    end else begin
      if (k == 0) e = q0.pop_front();
      else if (k == 1) e = q1.pop_front();
      else e = q2.pop_front();
      chk($sformatf("done_cycle%0d", k), cyc, e.cyc);
      chk($sformatf("sample_cnt%0d", k), sc, e.sc);
      chk($sformatf("err_cnt%0d", k), ec, e.ec);
      chk($sformatf("err_mask%0d", k), {25'd0, m}, {25'd0, e.mask});
      chk($sformatf("pass%0d", k), {31'd0, p}, {31'd0, e.pass});
`ifdef LOGIC_CHECKER_FIRST_ERR_EN
      chk($sformatf("first_vld%0d", k), {31'd0, fv}, {31'd0, e.fv});
      chk($sformatf("first_a%0d", k), {24'd0, fa}, {24'd0, e.fa});
      chk($sformatf("first_b%0d", k), {24'd0, fb}, {24'd0, e.fb});
      chk($sformatf("first_mask%0d", k), {25'd0, fm}, {25'd0, e.fm});
`endif
    end
  endtask

  logic dp0 = 1'b0, dp1 = 1'b0, dp2 = 1'b0;
  always @(negedge sys_clk) begin
    if (done0 && !dp0) mon(0, {16'd0, sc0}, {16'd0, ec0}, m0, pass0, fv0, fa0, fb0, fm0);
    if (done1 && !dp1) mon(1, {28'd0, sc1}, {28'd0, ec1}, m1, pass1, fv1, fa1, fb1, fm1);
    if (done2 && !dp2) mon(2, {28'd0, sc2}, {28'd0, ec2}, m2, pass2, fv2, fa2, fb2, fm2);
    dp0 <= done0;
    dp1 <= done1;
    dp2 <= done2;
  end

  // Inputs change just after the falling edge; the following rising edge samples them.
  task automatic step(input logic v, input logic [2:0] st, input smp_t x);
    @(negedge sys_clk);
    pi_valid = v;
    start    = st;
    s        = x;
  endtask

  task automatic push(input int k, input int sc, input int ec, input logic [6:0] mask, input logic pass,
                      input logic fv, input logic [7:0] fa, input logic [7:0] fb, input logic [6:0] fm);
    exp_t e;
    e = '{cyc + 2, sc, ec, mask, pass, fv, fa, fb, fm};
    if (k == 0) q0.push_back(e);
    else if (k == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask

  task automatic drain(input int k);
    int sz;
    for (int n = 0; n < 30; n++) begin
      sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
      if (sz == 0) return;
      step(1'b0, 3'b000, ZZ);
    end
    n_checks++;
    n_errors++;
    $display("FAIL done_timeout dut%0d actual=0 required=1", k);
    if (k == 0) q0.delete();
    else if (k == 1) q1.delete();
    else q2.delete();
  endtask

  initial begin
    #12;
    chk("rst_busy", {31'd0, busy0}, 0);
    chk("rst_done", {31'd0, done0}, 0);
    chk("rst_pass", {31'd0, pass0}, 0);
    chk("rst_cnts", {sc0, ec0}, 0);
    chk("rst_mask", {25'd0, m0}, 0);
    chk("rst_first", {fv0, fa0, fb0, fm0}, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // Run A: four clean samples.
    step(1'b0, 3'b001, ZZ);
    repeat (3) step(1'b1, 3'b000, GA);
    step(1'b1, 3'b000, GA);
    push(0, 4, 0, 7'h00, 1'b1, 1'b0, 8'h00, 8'h00, 7'h00);
    step(1'b0, 3'b000, ZZ);
    drain(0);

    // Run B: lane e wrong on sample 2 only.
    step(1'b0, 3'b001, ZZ);
    step(1'b1, 3'b000, GB);
    step(1'b1, 3'b000, BE);
    step(1'b1, 3'b000, GB);
    step(1'b1, 3'b000, GB);
    push(0, 4, 1, 7'b0000100, 1'b0, 1'b1, 8'hA5, 8'h3C, 7'b0000100);
    step(1'b0, 3'b000, ZZ);
    drain(0);
    chk("hold_err_cnt", {16'd0, ec0}, 1);

    // Start together with a bad valid from DONE: that sample must not be taken.
    step(1'b1, 3'b001, BI);
    step(1'b0, 3'b000, ZZ);
    chk("restart_busy", {31'd0, busy0}, 1);
    chk("restart_done", {31'd0, done0}, 0);
    chk("restart_clear", {sc0, ec0}, 0);
    chk("restart_mask", {25'd0, m0}, 0);
    chk("restart_first", {fv0, fa0, fb0, fm0}, 0);
    repeat (3) step(1'b1, 3'b000, GA);
    step(1'b1, 3'b000, GA);
    push(0, 4, 0, 7'h00, 1'b1, 1'b0, 8'h00, 8'h00, 7'h00);
    step(1'b0, 3'b000, ZZ);
    drain(0);

    // Run C: gapped valids, then extra bad valids after the fourth accept.
    step(1'b0, 3'b001, ZZ);
    step(1'b1, 3'b000, GA);
    step(1'b0, 3'b000, GA);
    step(1'b1, 3'b000, GA);
    step(1'b1, 3'b000, GA);
    step(1'b0, 3'b000, GA);
    step(1'b1, 3'b000, GA);
    push(0, 4, 0, 7'h00, 1'b1, 1'b0, 8'h00, 8'h00, 7'h00);
    repeat (3) step(1'b1, 3'b000, BE);
    step(1'b0, 3'b000, ZZ);
    drain(0);
    repeat (2) step(1'b0, 3'b000, ZZ);
    chk("extra_sample_cnt", {16'd0, sc0}, 4);
    chk("extra_err_cnt", {16'd0, ec0}, 0);
    chk("extra_pass", {31'd0, pass0}, 1);

    // Asynchronous reset mid-run after two accepts.
    step(1'b0, 3'b001, ZZ);
    step(1'b1, 3'b000, GA);
    step(1'b1, 3'b000, BE);
    step(1'b0, 3'b000, ZZ);
    #2 sys_rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy0}, 0);
    chk("arst_done_pass", {30'd0, done0, pass0}, 0);
    chk("arst_cnts", {sc0, ec0}, 0);
    chk("arst_mask", {25'd0, m0}, 0);
    chk("arst_first", {fv0, fa0, fb0, fm0}, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    step(1'b0, 3'b001, ZZ);
    repeat (3) step(1'b1, 3'b000, GA);
    step(1'b1, 3'b000, GA);
    push(0, 4, 0, 7'h00, 1'b1, 1'b0, 8'h00, 8'h00, 7'h00);
    step(1'b0, 3'b000, ZZ);
    drain(0);

    // 4-bit counters: 12 of 12 bad, then 15 of 15 bad (counter hits all-ones).
    step(1'b0, 3'b010, ZZ);
    repeat (11) step(1'b1, 3'b000, BI);
    step(1'b1, 3'b000, BI);
    push(1, 12, 12, 7'b1000000, 1'b0, 1'b1, 8'hA5, 8'h3C, 7'b1000000);
    step(1'b0, 3'b000, ZZ);
    drain(1);

    step(1'b0, 3'b100, ZZ);
    repeat (14) step(1'b1, 3'b000, BI);
    step(1'b1, 3'b000, BI);
    push(2, 15, 15, 7'b1000000, 1'b0, 1'b1, 8'hA5, 8'h3C, 7'b1000000);
    step(1'b0, 3'b000, ZZ);
    drain(2);
    repeat (2) step(1'b0, 3'b000, ZZ);
    chk("sat_hold", {28'd0, ec2}, 15);
    chk("dut0_untouched", {16'd0, sc0}, 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
